// File: rtl/switch_router_nport.sv
// Routes one {addr, data} source stream to NUM_PORTS output channels, each with its own
// FIFO, valid/ready backpressure and a saturating delivered-packet counter.
module switch_router_nport #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_W     = 48,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int SEL_LSB    = 0,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          src_valid,
    input  logic [ADDR_W-1:0]             src_addr,
    input  logic [DATA_W-1:0]             src_data,
    output logic                          src_ready,
    output logic [NUM_PORTS-1:0]          dst_valid,
    input  logic [NUM_PORTS-1:0]          dst_ready,
    output logic [NUM_PORTS*ADDR_W-1:0]   dst_addr,
    output logic [NUM_PORTS*DATA_W-1:0]   dst_data,
    output logic [NUM_PORTS*CNT_W-1:0]    dst_count
);
    localparam int SEL_W = $clog2(NUM_PORTS);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int PKT_W = ADDR_W + DATA_W;

    logic [SEL_W-1:0]     sel;
    logic                 is_bcast;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;

    assign sel      = src_addr[SEL_LSB +: SEL_W];
    assign is_bcast = &src_addr;

    // A broadcast waits until every channel has room, so it always lands everywhere at once.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        src_ready = 1'b0;
        if (!reset) begin
            src_ready = is_bcast ? ~|full : ~full[sel];
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [PKT_W-1:0] mem_q [FIFO_DEPTH];
        logic [PKT_W-1:0] head;

        assign push[i]  = src_valid && src_ready && (is_bcast || (sel == SEL_W'(i)));
        assign pop[i]   = !empty[i] && dst_ready[i];
        assign empty[i] = (wr_ptr_q == rd_ptr_q);
        assign full[i]  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                          (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);

        always_comb begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push[i]);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop[i]);
            cnt_d    = cnt_q;
            if (pop[i] && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            if (reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // NOTE: storage is not reset; the pointers alone decide which entries are meaningful.
        always_ff @(posedge clk) begin
            if (push[i]) begin
                mem_q[wr_ptr_q[IDX_W-1:0]] <= {src_addr, src_data};
            end
        end

        assign head                          = mem_q[rd_ptr_q[IDX_W-1:0]];
        assign dst_valid[i]                  = !empty[i];
        assign dst_addr[i*ADDR_W +: ADDR_W]  = empty[i] ? '0 : head[PKT_W-1:DATA_W];
        assign dst_data[i*DATA_W +: DATA_W]  = empty[i] ? '0 : head[DATA_W-1:0];
        assign dst_count[i*CNT_W +: CNT_W]   = cnt_q;
    end
endmodule

// File: tb/tb_switch_router_nport.sv
// Directed bench for switch_router_nport: two instances share stimulus, one with 16-bit
// counters and one with 4-bit counters for the saturation case.
module tb_switch_router_nport;
    logic          clk = 1'b0;
    logic          reset;
    logic          src_valid;
    logic [47:0]   src_addr;
    logic [31:0]   src_data;
    logic [3:0]    dst_ready;

    logic          src_ready_a, src_ready_b;
    logic [3:0]    dst_valid_a, dst_valid_b;
    logic [191:0]  dst_addr_a, dst_addr_b;
    logic [127:0]  dst_data_a, dst_data_b;
    logic [63:0]   dst_count_a;
    logic [15:0]   dst_count_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    switch_router_nport #(.NUM_PORTS(4), .ADDR_W(48), .DATA_W(32), .FIFO_DEPTH(4),
                          .SEL_LSB(0), .CNT_W(16)) u_dut_a (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_addr(src_addr),
        .src_data(src_data), .src_ready(src_ready_a), .dst_valid(dst_valid_a),
        .dst_ready(dst_ready), .dst_addr(dst_addr_a), .dst_data(dst_data_a),
        .dst_count(dst_count_a)
    );

    switch_router_nport #(.NUM_PORTS(4), .ADDR_W(48), .DATA_W(32), .FIFO_DEPTH(4),
                          .SEL_LSB(0), .CNT_W(4)) u_dut_b (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_addr(src_addr),
        .src_data(src_data), .src_ready(src_ready_b), .dst_valid(dst_valid_b),
        .dst_ready(dst_ready), .dst_addr(dst_addr_b), .dst_data(dst_data_b),
        .dst_count(dst_count_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] addr_of(input int p);
        return dst_addr_a[p*48 +: 48];
    endfunction

    function automatic logic [31:0] data_of(input int p);
        return dst_data_a[p*32 +: 32];
    endfunction

    function automatic logic [15:0] count_a(input int p);
        return dst_count_a[p*16 +: 16];
    endfunction

    function automatic logic [3:0] count_b(input int p);
        return dst_count_b[p*4 +: 4];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push n packets to port p while that port drains every cycle; head order is scored.
    task automatic stream(input int p, input int n, input logic [31:0] base);
        int stalls = 0;
        int bad    = 0;
        int idx    = 0;
        dst_ready = 4'b0001 << p;
        src_valid = 1'b1;
        src_addr  = 48'(p);
        for (int k = 0; k < n; k++) begin
            src_data = base + 32'(k);
            #1;
            if (!src_ready_a) stalls++;
            if (dst_valid_a[p]) begin
                if (data_of(p) !== base + 32'(idx)) bad++;
                idx++;
            end
            tick();
        end
        src_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin
            #1;
            if (dst_valid_a[p]) begin
                if (data_of(p) !== base + 32'(idx)) bad++;
                idx++;
            end
            tick();
        end
        dst_ready = 4'b0000;
        check("stream_stalls", 64'(stalls), 64'd0);
        check("stream_order_errs", 64'(bad), 64'd0);
        check("stream_delivered", 64'(idx), 64'(n));
    endtask

    initial begin
        reset     = 1'b1;
        src_valid = 1'b0;
        src_addr  = '0;
        src_data  = '0;
        dst_ready = '0;

        // Reset then idle
        tick();
        tick();
        check("rst_src_ready_a", 64'(src_ready_a), 64'd0);
        check("rst_dst_valid", 64'(dst_valid_a), 64'd0);
        reset = 1'b0;
        tick();
        check("idle_dst_valid_a", 64'(dst_valid_a), 64'd0);
        check("idle_dst_valid_b", 64'(dst_valid_b), 64'd0);
        check("idle_count_a", dst_count_a, 64'd0);
        check("idle_count_b", 64'(dst_count_b), 64'd0);
        check("idle_src_ready_a", 64'(src_ready_a), 64'd1);
        check("idle_src_ready_b", 64'(src_ready_b), 64'd1);

        // Unicast to channel 2, one-cycle latency
        src_valid = 1'b1;
        src_addr  = 48'h0000_0000_0002;
        src_data  = 32'hDEAD_BEEF;
        #1;
        check("uni_src_ready", 64'(src_ready_a), 64'd1);
        check("uni_no_passthru", 64'(dst_valid_a), 64'd0);
        tick();
        src_valid = 1'b0;
        check("uni_valid", 64'(dst_valid_a), 64'h4);
        check("uni_addr", 64'(addr_of(2)), 64'h2);
        check("uni_data", 64'(data_of(2)), 64'hDEAD_BEEF);
        check("uni_idle_addr0", 64'(addr_of(0)), 64'd0);
        dst_ready = 4'b0100;
        tick();
        dst_ready = 4'b0000;
        check("uni_popped", 64'(dst_valid_a), 64'd0);
        check("uni_count2", 64'(count_a(2)), 64'd1);

        // Fill channel 1 and backpressure the fifth packet
        src_valid = 1'b1;
        src_addr  = 48'h1;
        for (int k = 0; k < 4; k++) begin
            src_data = 32'h1000 + 32'(k);
            #1;
            check("fill_ready", 64'(src_ready_a), 64'd1);
            tick();
        end
        src_data = 32'h1004;
        #1;
        check("full_ready_low", 64'(src_ready_a), 64'd0);
        check("full_valid", 64'(dst_valid_a), 64'h2);
        tick();
        dst_ready = 4'b0010;
        #1;
        check("full_ready_no_dst_dep", 64'(src_ready_a), 64'd0);
        tick();
        dst_ready = 4'b0000;
        #1;
        check("after_pop_ready", 64'(src_ready_a), 64'd1);
        check("after_pop_head", 64'(data_of(1)), 64'h1001);
        tick();
        src_valid = 1'b0;
        dst_ready = 4'b0010;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check("drain1_order", 64'(data_of(1)), 64'h1000 + 64'(k));
            tick();
        end
        dst_ready = 4'b0000;
        check("drain1_empty", 64'(dst_valid_a), 64'd0);
        check("drain1_count", 64'(count_a(1)), 64'd5);

        // Streaming through channel 0 across pointer wrap
        stream(0, 20, 32'h5000);
        check("stream_count0", 64'(count_a(0)), 64'd20);

        // Broadcast blocked by a full channel 3
        src_valid = 1'b1;
        src_addr  = 48'h3;
        for (int k = 0; k < 4; k++) begin
            src_data = 32'h3000 + 32'(k);
            tick();
        end
        src_addr = 48'hFFFF_FFFF_FFFF;
        src_data = 32'hB0B0_B0B0;
        #1;
        check("bc_ready_low", 64'(src_ready_a), 64'd0);
        tick();
        check("bc_not_written", 64'(dst_valid_a), 64'h8);
        dst_ready = 4'b1000;
        #1;
        check("bc_ready_no_dst_dep", 64'(src_ready_a), 64'd0);
        tick();
        dst_ready = 4'b0000;
        #1;
        check("bc_ready_high", 64'(src_ready_a), 64'd1);
        tick();
        src_valid = 1'b0;
        check("bc_all_valid", 64'(dst_valid_a), 64'hF);
        check("bc_data0", 64'(data_of(0)), 64'hB0B0_B0B0);
        check("bc_data1", 64'(data_of(1)), 64'hB0B0_B0B0);
        check("bc_data2", 64'(data_of(2)), 64'hB0B0_B0B0);
        check("bc_addr0", 64'(addr_of(0)), 64'hFFFF_FFFF_FFFF);
        check("bc_head3", 64'(data_of(3)), 64'h3001);
        dst_ready = 4'b1111;
        tick();
        check("bc_others_drained", 64'(dst_valid_a), 64'h8);
        check("bc_ch3_order", 64'(data_of(3)), 64'h3002);
        tick();
        tick();
        check("bc_ch3_last", 64'(data_of(3)), 64'hB0B0_B0B0);
        tick();
        dst_ready = 4'b0000;
        check("bc_all_empty", 64'(dst_valid_a), 64'd0);
        check("bc_count3", 64'(count_a(3)), 64'd5);
        check("bc_count0", 64'(count_a(0)), 64'd21);

        // Saturation: channel 1 has 6 pops so far; 17 more
        stream(1, 17, 32'h7000);
        check("sat_count_b", 64'(count_b(1)), 64'hF);
        check("sat_count_a", 64'(count_a(1)), 64'd23);
        check("sat_other_b", 64'(count_b(2)), 64'd2);

        // Reset with packets queued
        src_valid = 1'b1;
        src_addr  = 48'h2;
        src_data  = 32'hAAAA_0001;
        tick();
        src_data  = 32'hAAAA_0002;
        tick();
        src_valid = 1'b0;
        check("pre_rst_valid", 64'(dst_valid_a), 64'h4);
        reset = 1'b1;
        #1;
        check("mid_rst_src_ready", 64'(src_ready_b), 64'd0);
        tick();
        check("mid_rst_valid_a", 64'(dst_valid_a), 64'd0);
        check("mid_rst_valid_b", 64'(dst_valid_b), 64'd0);
        check("mid_rst_count_a", dst_count_a, 64'd0);
        check("mid_rst_count_b", 64'(dst_count_b), 64'd0);
        check("mid_rst_data2", 64'(data_of(2)), 64'd0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", 64'(src_ready_a), 64'd1);
        check("post_rst_valid", 64'(dst_valid_a), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/switch_router_nport.md
Name: switch_router_nport

Overview:
- Parametrised successor to the single-channel switch datapath.
- Accepts one source stream of {addr, data} packets and routes each packet to one of NUM_PORTS output channels. The channel is selected by address bits; a broadcast address goes to every channel.
- Each output channel has its own FIFO with valid/ready backpressure and a saturating delivered-packet counter.
- Sits between the source-side packet driver and per-port sinks/monitors.

Parameters:
- NUM_PORTS, 4, number of output channels; power of two, 2..16.
- ADDR_W, 48, packet address width.
- DATA_W, 32, packet data width.
- FIFO_DEPTH, 4, entries per output FIFO; power of two, >=2.
- SEL_LSB, 0, LSB of the port-select field in src_addr; field width is log2(NUM_PORTS).
- CNT_W, 16, width of each per-port delivered counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- src_valid  in  1  source packet valid.
- src_addr  in  ADDR_W  source packet address.
- src_data  in  DATA_W  source packet data.
- src_ready  out  1  switch can accept the presented packet.
- dst_valid  out  NUM_PORTS  per-channel head valid.
- dst_ready  in  NUM_PORTS  per-channel sink ready.
- dst_addr  out  NUM_PORTS*ADDR_W  per-channel head address; channel i occupies [i*ADDR_W +: ADDR_W].
- dst_data  out  NUM_PORTS*DATA_W  per-channel head data; same packing.
- dst_count  out  NUM_PORTS*CNT_W  per-channel delivered-packet counter.

Behaviour:
- Single clock domain: clk.
- reset is synchronous and active-high; sampled on the rising edge of clk.
- Reset state:
  - all FIFOs empty; read/write pointers 0.
  - dst_valid = 0; dst_addr = 0; dst_data = 0; dst_count = 0.
  - src_ready = 0 while reset is high.
- Routing:
  - sel = src_addr[SEL_LSB +: log2(NUM_PORTS)].
  - Broadcast when src_addr equals all-ones of ADDR_W; broadcast ignores sel.
- src_ready (combinational from src_addr and FIFO state, no dependence on dst_ready):
  - unicast: !full[sel].
  - broadcast: AND of !full over all channels.
- Accept: on the rising edge where src_valid && src_ready.
  - unicast: packet pushed into FIFO[sel].
  - broadcast: packet pushed into every FIFO in the same cycle.
- Source handshake rules:
  - src_valid may be asserted with src_ready low; the source holds addr/data stable until accepted.
  - The switch never drops a packet.
- Latency: a packet accepted at edge N makes dst_valid[i] high after edge N, i.e. visible in cycle N+1. No same-cycle pass-through.
- Output channel i:
  - dst_valid[i] = !empty[i].
  - dst_addr/dst_data slices present the FIFO head while valid, and are 0 when not valid.
  - Pop on the edge where dst_valid[i] && dst_ready[i].
  - Channels are fully independent; a stalled channel blocks only packets routed to it, including broadcasts.
- Simultaneous push and pop on one FIFO:
  - non-full: both occur; occupancy unchanged.
  - full: no push (src_ready is already low for that target); the pop proceeds, and the push may be accepted the following cycle.
  - empty: pop is impossible because dst_valid=0; the push lands, and valid rises next cycle.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits; wrap-around via the MSB toggle distinguishes full from empty. Order within each channel is strictly FIFO.
- dst_count[i]:
  - increments by 1 on each pop of channel i.
  - saturates at all-ones with no wrap.
  - cleared only by reset.
- Reset mid-operation: all queued packets are discarded; counters are cleared; outputs return to reset values on the next edge.
- Unknown or X on src_addr while src_valid=0 must not affect state.

Test Plan:
- Reset then idle -> src_ready=0 during reset; after release all dst_valid=0, dst_count=0, src_ready=1.
- Unicast routing, NUM_PORTS=4:
  - send addr 48'h0000_0000_0002, data 32'hDEAD_BEEF -> only dst_valid[2] rises the next cycle, with head addr/data matching.
  - pop -> dst_count[2]=1.
- Fill and backpressure, FIFO_DEPTH=4, dst_ready[1]=0:
  - send 5 packets with sel=1 -> first 4 accepted; src_ready=0 on the 5th.
  - raise dst_ready[1] for one cycle -> 5th accepted the next cycle; data emerges in send order.
- Broadcast with a stall:
  - channel 3 full, send addr 48'hFFFF_FFFF_FFFF -> src_ready=0 and no channel is written.
  - drain one entry of channel 3 -> packet lands in all 4 FIFOs in the same cycle.
- Simultaneous push/pop plus wrap:
  - stream 20 packets to channel 0 with dst_ready[0]=1 throughout -> no stall after the first fill, order preserved across pointer wrap, dst_count[0]=20.
- Counter saturation and mid-run reset, CNT_W=4:
  - 17 pops on channel 1 -> dst_count[1]=4'hF.
  - assert reset with 2 packets queued -> dst_valid=0 and counters=0 after one edge.
